// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request channel with a fixed,
// parameterised wait time before each one-cycle response strobe.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            lat_we, lat_we_nx;
  logic [DW-1:0]   lat_addr, lat_addr_nx;
  logic [DW-1:0]   lat_wdata, lat_wdata_nx;
  logic            resp_valid_nx;
  logic            resp_err_nx;
  logic [DW-1:0]   resp_rdata_nx;

  logic            cur_we;
  logic [DW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic            cur_err;
  logic [AW-1:0]   cur_idx;
  logic            enter_resp;
  logic            mem_we;

  logic [DW-1:0]   mem [DEPTH];

  // With zero latency RESP is entered on the accepting edge itself, so the
  // live request inputs stand in for the latched copy while in IDLE.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
    cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
    cur_idx = cur_addr[AW+1:2];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    lat_we_nx     = lat_we;
    lat_addr_nx   = lat_addr;
    lat_wdata_nx  = lat_wdata;
    resp_valid_nx = 1'b0;
    resp_err_nx   = 1'b0;
    resp_rdata_nx = resp_rdata;
    enter_resp    = 1'b0;
    mem_we        = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          lat_we_nx    = req_we;
          lat_addr_nx  = req_addr;
          lat_wdata_nx = req_wdata;
          if (LATENCY > 0) begin
            state_nx = WAIT;
            cnt_nx   = CW'(LATENCY);
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) enter_resp = 1'b1;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Commit/read happens on the edge that enters RESP.
    if (enter_resp) begin
      state_nx      = RESP;
      resp_valid_nx = 1'b1;
      resp_err_nx   = cur_err;
      resp_rdata_nx = (cur_we || cur_err) ? '0 : mem[cur_idx];
      mem_we        = cur_we && !cur_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lat_we     <= lat_we_nx;
      lat_addr   <= lat_addr_nx;
      lat_wdata  <= lat_wdata_nx;
      resp_valid <= resp_valid_nx;
      resp_err   <= resp_err_nx;
      resp_rdata <= resp_rdata_nx;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= cur_wdata;
  end

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven transactions on a
// LATENCY=2 instance with a response scoreboard, plus LATENCY=0 corner cases.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        l0_req_valid, l0_req_we;
  logic [31:0] l0_req_addr, l0_req_wdata;
  logic        l0_req_ready, l0_resp_valid, l0_resp_err, l0_busy;
  logic [31:0] l0_resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(l0_req_valid), .req_ready(l0_req_ready), .req_we(l0_req_we),
    .req_addr(l0_req_addr), .req_wdata(l0_req_wdata),
    .resp_valid(l0_resp_valid), .resp_rdata(l0_resp_rdata), .resp_err(l0_resp_err),
    .busy(l0_busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs [16];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_vs_busy", 32'(req_ready), 32'(!busy));
      if (resp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("err_outside_resp", 32'(resp_err), 32'd0);
      end
    end
  end

  // Presents one request when ready; req_valid is left asserted afterwards.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      sb.push_back('{exp_rdata, exp_err, cyc + 1 + LAT});
      last_acc = cyc + 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int prev_acc;
    logic [31:0] rd_addr [4];
    logic [31:0] rd_exp  [4];

    vecs = '{
      '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h0000_0014, 32'hA5A5_0001, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h0000_0016, 32'h0BAD_F00D, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h0000_0800, 32'h0000_0BAD, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h0000_0410, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h0000_0410, 32'h0000_0077, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h0000_0014, 32'h0000_0000, 32'hA5A5_0001, 1'b0},
      '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0},
      '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1111_1111, 1'b0},
      '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1}
    };

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    l0_req_valid = 1'b0; l0_req_we = 1'b0; l0_req_addr = '0; l0_req_wdata = '0;

    // Outputs while held in reset
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    // LATENCY=0: response strobe in the cycle right after acceptance
    @(negedge clk);
    l0_req_valid = 1'b1; l0_req_we = 1'b1; l0_req_addr = 32'h0; l0_req_wdata = 32'h1234_5678;
    @(posedge clk); #1 l0_req_valid = 1'b0;
    @(negedge clk);
    check("l0_wr_valid", 32'(l0_resp_valid), 32'd1);
    check("l0_wr_ready", 32'(l0_req_ready), 32'd0);
    check("l0_wr_busy", 32'(l0_busy), 32'd1);
    check("l0_wr_err", 32'(l0_resp_err), 32'd0);
    check("l0_wr_rdata", l0_resp_rdata, 32'd0);
    @(negedge clk);
    check("l0_idle_valid", 32'(l0_resp_valid), 32'd0);
    check("l0_idle_ready", 32'(l0_req_ready), 32'd1);
    l0_req_valid = 1'b1; l0_req_we = 1'b0; l0_req_addr = 32'h0;
    @(posedge clk); #1 l0_req_valid = 1'b0;
    @(negedge clk);
    check("l0_rd_valid", 32'(l0_resp_valid), 32'd1);
    check("l0_rd_rdata", l0_resp_rdata, 32'h1234_5678);
    check("l0_rd_ready", 32'(l0_req_ready), 32'd0);
    @(negedge clk);
    check("l0_after_valid", 32'(l0_resp_valid), 32'd0);
    check("l0_after_ready", 32'(l0_req_ready), 32'd1);
    check("l0_rdata_hold", l0_resp_rdata, 32'h1234_5678);

    // Table of single transactions
    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      req_valid = 1'b0;
      drain();
    end

    // Request inputs wiggle during WAIT: must be ignored
    do_req(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("wait_ready0", 32'(req_ready), 32'd0);
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check("wait_ready1", 32'(req_ready), 32'd0);
    req_addr = 32'h3;
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    do_req(1'b0, 32'h14, 32'h0, 32'hA5A5_0001, 1'b0);
    req_valid = 1'b0;
    drain();

    // Continuous req_valid: one acceptance every LAT+2 cycles
    rd_addr = '{32'h10, 32'h14, 32'h3FC, 32'h20};
    rd_exp  = '{32'hDEAD_BEEF, 32'hA5A5_0001, 32'hCAFE_F00D, 32'h1111_1111};
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, rd_addr[i], 32'h0, rd_exp[i], 1'b0);
      if (i > 0) check("accept_spacing", 32'(last_acc - prev_acc), 32'(LAT + 2));
      prev_acc = last_acc;
    end
    req_valid = 1'b0;
    drain();

    // Reset in WAIT abandons a write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_err", 32'(resp_err), 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_req(1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0);
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
